mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle control FSM for the MIPS core. It sequences a shared-memory datapath (one ALU, one memory port, instruction register) over several cycles per instruction. It generates every mux select, write strobe and ALU function for LW, SW, R-type (ADD/SUB/AND/OR/SLT), BEQ, BNE, ADDI, SLTI and J. Memory accesses use a ready handshake with a watchdog timeout. Unknown opcodes and functs trap to a sticky error state.

## Interface
- TIMEOUT, 16: maximum cycles to wait for `memready` in a memory state; range 0..255; 0 disables the watchdog.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; low forces state FETCH and clears the wait counter
- op  in  6  opcode from the instruction register; stable from DECODE to end of instruction
- funct  in  6  funct field from the instruction register
- zero  in  1  ALU zero flag, combinational, same cycle
- memready  in  1  memory completes the current access this cycle
- pcen  out  1  PC register enable
- irwrite  out  1  instruction register load
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- regwrite  out  1  register file write
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  writeback data select: 0 = ALUOut, 1 = memory data
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = register B, 01 = 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- state  out  4  current state encoding, for debug
- err  out  1  high in ERROR

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, ERROR 15. Unused encodings go to ERROR.
- Outputs are Moore, decoded from state. The one exception is `pcen`, which also depends on `memready`, `zero` and `op[0]`. Any output not listed for a state is 0.
- FETCH:
  - outputs: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00.
  - irwrite = pcen = memready.
  - Stays in FETCH until memready, then goes to DECODE.
- DECODE:
  - outputs: alusrca=0, alusrcb=11, alucontrol=010 (precomputes the branch target).
  - transitions by op: LW/SW → MEMADR; R-type with a legal funct → EXECUTE; BEQ/BNE → BRANCH; ADDI/SLTI → IMMEX; J → JUMP.
  - anything else, including an R-type with an illegal funct → ERROR.
- MEMADR:
  - outputs: alusrca=1, alusrcb=10, alucontrol=010.
  - LW → MEMRD; SW → MEMWR.
- MEMRD: iord=1. Holds until memready, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1, held for the whole state. Holds until memready, then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct → ALUWB.
  - funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- ALUWB: regdst=1, memtoreg=0, regwrite=1 → FETCH.
- BRANCH:
  - outputs: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01.
  - pcen = zero XOR op[0], so BEQ takes the branch on zero=1 and BNE on zero=0.
  - → FETCH.
- IMMEX: alusrca=1, alusrcb=10 → IMMWB.
  - alucontrol = 010 for ADDI, 111 for SLTI.
- IMMWB: regdst=0, memtoreg=0, regwrite=1 → FETCH.
- JUMP: pcsrc=10, pcen=1 → FETCH.
- ERROR: err=1; all strobes are 0. ERROR is sticky and exits only via reset.
- Watchdog:
  - An 8-bit wait counter clears on entry to FETCH, MEMRD or MEMWR.
  - It increments each cycle that state is held with memready=0.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with memready still 0, the next state is ERROR. memready=1 on that same cycle wins.

## Timing
- Reset (reset low, any time, asynchronous): state=FETCH, counter=0, err=0.
  - While reset is low, pcen, irwrite, memwrite and regwrite are forced to 0.
  - The first fetch begins on the first rising edge after reset is released.
  - Reset mid-instruction abandons it; no write strobe fires.
- Cycles per instruction with memready tied high: LW 5, SW 4, R-type 4, ADDI/SLTI 4, BEQ/BNE 3, J 3.
- Each cycle that memready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Every write strobe is a single-cycle pulse, except memwrite, which is held through all of MEMWR.
- op and funct are sampled combinationally in DECODE, EXECUTE, IMMEX and BRANCH, and must not change within an instruction.

## Test plan
- Reset: hold reset low, then release → state=0, all strobes 0 while low; first cycle after release, pcen=irwrite=1 with memready=1.
- Opcode sequence: LW, SW, ADD, SUB, AND, OR, SLT, ADDI, SLTI, J with memready=1 → state paths as specified, cycle counts 5/4/4/4/4/4/4/4/4/3, correct alucontrol per state.
- Branches: BEQ with zero=1 → pcen=1 and pcsrc=01 in BRANCH; BEQ with zero=0 → pcen=0; BNE with zero=0 → pcen=1; BNE with zero=1 → pcen=0.
- Memory stalls: LW with memready low for 3 cycles in MEMRD → MEMRD held 4 cycles, then regwrite=1 in MEMWB; SW stalled 2 cycles → memwrite high for 3 consecutive cycles.
- Watchdog: TIMEOUT=4, memready stuck at 0 in FETCH → ERROR, err=1 after the 4th waiting cycle and stays sticky; TIMEOUT=0 → waits indefinitely.
- Illegal decode: op=111111, or R-type with funct=000000 → ERROR from DECODE, no regwrite/memwrite ever; then assert reset → FETCH with err=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the shared-memory MIPS datapath: sequences
// fetch/decode/execute/memory/writeback and traps illegal encodings or memory stalls.
module mips_multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state,
    output logic       err
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_IMMEX   = 4'd9;
    localparam logic [3:0] S_IMMWB   = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ERROR   = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [3:0] state_next;
    logic [7:0] wait_cnt;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       waiting;
    logic       timed_out;
    logic       pcen_m, irwrite_m, memwrite_m, regwrite_m;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // The timeout fires on the waiting cycle whose increment would make the count reach TIMEOUT.
    assign waiting   = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !memready;
    assign timed_out = waiting && (TIMEOUT_C != 8'd0)
                       && (({1'b0, wait_cnt} + 9'd1) == {1'b0, TIMEOUT_C});

    always_comb begin
        state_next = S_ERROR;
        case (state)
            S_FETCH:   state_next = timed_out ? S_ERROR : (memready ? S_DECODE : S_FETCH);
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     state_next = S_MEMADR;
                    OP_RTYPE:         state_next = funct_ok ? S_EXECUTE : S_ERROR;
                    OP_BEQ, OP_BNE:   state_next = S_BRANCH;
                    OP_ADDI, OP_SLTI: state_next = S_IMMEX;
                    OP_J:             state_next = S_JUMP;
                    default:          state_next = S_ERROR;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = timed_out ? S_ERROR : (memready ? S_MEMWB : S_MEMRD);
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   state_next = timed_out ? S_ERROR : (memready ? S_FETCH : S_MEMWR);
            S_EXECUTE: state_next = S_ALUWB;
            S_ALUWB:   state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_IMMEX:   state_next = S_IMMWB;
            S_IMMWB:   state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            default:   state_next = S_ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (waiting && (wait_cnt != '1))
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        pcen_m     = 1'b0;
        irwrite_m  = 1'b0;
        memwrite_m = 1'b0;
        regwrite_m = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = 3'b000;
        err        = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                irwrite_m  = memready;
                pcen_m     = memready;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_m = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_m = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_m = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen_m     = zero ^ op[0];
            end
            S_IMMEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = (op == OP_SLTI) ? 3'b111 : 3'b010;
            end
            S_IMMWB: regwrite_m = 1'b1;
            S_JUMP: begin
                pcsrc  = 2'b10;
                pcen_m = 1'b1;
            end
            S_ERROR: err = 1'b1;
            default: ;
        endcase
    end

    assign pcen     = reset & pcen_m;
    assign irwrite  = reset & irwrite_m;
    assign memwrite = reset & memwrite_m;
    assign regwrite = reset & regwrite_m;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: each stimulus cycle queues the expected
// state/control vector and a negedge monitor pops and compares it.
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
                           BRANCH = 4'd8, IMMEX = 4'd9, IMMWB = 4'd10, JUMP = 4'd11,
                           ERROR = 4'd15;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memready;

    logic       pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg, alusrca, err;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic       pcen2, irwrite2, iord2, memwrite2, regwrite2, regdst2, memtoreg2, alusrca2, err2;
    logic [1:0] alusrcb2, pcsrc2;
    logic [2:0] alucontrol2;
    logic [3:0] state2;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [19:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .pcen(pcen), .irwrite(irwrite), .iord(iord), .memwrite(memwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state), .err(err)
    );

    // Second instance with the watchdog disabled and memory never ready.
    mips_multicycle_ctrl #(.TIMEOUT(0)) dut_nowd (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(1'b0),
        .pcen(pcen2), .irwrite(irwrite2), .iord(iord2), .memwrite(memwrite2), .regwrite(regwrite2),
        .regdst(regdst2), .memtoreg(memtoreg2), .alusrca(alusrca2), .alusrcb(alusrcb2),
        .pcsrc(pcsrc2), .alucontrol(alucontrol2), .state(state2), .err(err2)
    );

    wire [19:0] act  = {state, err, pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
                        alusrca, alusrcb, pcsrc, alucontrol};
    wire [19:0] act2 = {state2, err2, pcen2, irwrite2, iord2, memwrite2, regwrite2, regdst2,
                        memtoreg2, alusrca2, alusrcb2, pcsrc2, alucontrol2};

    function automatic logic [19:0] exp_vec(input logic [3:0] st, input logic [5:0] o,
                                            input logic [5:0] f, input logic z,
                                            input logic mr, input logic rs);
        logic e, pe, irw, io, mw, rw, rd, mtr, sa;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {e, pe, irw, io, mw, rw, rd, mtr, sa} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b000;
        case (st)
            FETCH:   begin sb = 2'b01; ac = 3'b010; irw = mr; pe = mr; end
            DECODE:  begin sb = 2'b11; ac = 3'b010; end
            MEMADR:  begin sa = 1'b1; sb = 2'b10; ac = 3'b010; end
            MEMRD:   io = 1'b1;
            MEMWB:   begin mtr = 1'b1; rw = 1'b1; end
            MEMWR:   begin io = 1'b1; mw = 1'b1; end
            EXECUTE: begin
                sa = 1'b1;
                case (f)
                    6'b100000: ac = 3'b010;
                    6'b100010: ac = 3'b110;
                    6'b100100: ac = 3'b000;
                    6'b100101: ac = 3'b001;
                    6'b101010: ac = 3'b111;
                    default:   ac = 3'bxxx;
                endcase
            end
            ALUWB:   begin rd = 1'b1; rw = 1'b1; end
            BRANCH:  begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = (o == 6'b000100) ? z : !z; end
            IMMEX:   begin sa = 1'b1; sb = 2'b10; ac = (o == 6'b001010) ? 3'b111 : 3'b010; end
            IMMWB:   rw = 1'b1;
            JUMP:    begin ps = 2'b10; pe = 1'b1; end
            ERROR:   e = 1'b1;
            default: ;
        endcase
        if (!rs) begin pe = 1'b0; irw = 1'b0; mw = 1'b0; rw = 1'b0; end
        return {st, e, pe, irw, io, mw, rw, rd, mtr, sa, sb, ps, ac};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [19:0] ev;
            string nm;
            ev = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (act !== ev) begin
                bad++;
                $display("FAIL %s: got state=%0d vec=%b expected state=%0d vec=%b",
                         nm, act[19:16], act[15:0], ev[19:16], ev[15:0]);
            end
        end
    end

    task automatic step(input string nm, input logic [3:0] es, input logic mr, input logic z);
        memready = mr;
        zero     = z;
        exp_q.push_back(exp_vec(es, op, funct, z, mr, reset));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step("reset", FETCH, 1'b1, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; op = '0; funct = '0; zero = 1'b0; memready = 1'b1;
        @(posedge clk);
        #1;
        step("reset_low0", FETCH, 1'b1, 1'b0);
        step("reset_low1", FETCH, 1'b1, 1'b0);
        reset = 1'b1;

        op = 6'b100011;
        step("lw", FETCH, 1, 0); step("lw", DECODE, 1, 0); step("lw", MEMADR, 1, 0);
        step("lw", MEMRD, 1, 0); step("lw", MEMWB, 1, 0);
        op = 6'b101011;
        step("sw", FETCH, 1, 0); step("sw", DECODE, 1, 0); step("sw", MEMADR, 1, 0);
        step("sw", MEMWR, 1, 0);
        op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: funct = 6'b100000;
                1: funct = 6'b100010;
                2: funct = 6'b100100;
                3: funct = 6'b100101;
                default: funct = 6'b101010;
            endcase
            step("rtype", FETCH, 1, 0); step("rtype", DECODE, 1, 0);
            step("rtype", EXECUTE, 1, 0); step("rtype", ALUWB, 1, 0);
        end
        op = 6'b001000;
        step("addi", FETCH, 1, 0); step("addi", DECODE, 1, 0);
        step("addi", IMMEX, 1, 0); step("addi", IMMWB, 1, 0);
        op = 6'b001010;
        step("slti", FETCH, 1, 0); step("slti", DECODE, 1, 0);
        step("slti", IMMEX, 1, 0); step("slti", IMMWB, 1, 0);
        op = 6'b000010;
        step("j", FETCH, 1, 0); step("j", DECODE, 1, 0); step("j", JUMP, 1, 0);

        op = 6'b000100;
        step("beq_t", FETCH, 1, 0); step("beq_t", DECODE, 1, 0); step("beq_t", BRANCH, 1, 1);
        step("beq_n", FETCH, 1, 0); step("beq_n", DECODE, 1, 0); step("beq_n", BRANCH, 1, 0);
        op = 6'b000101;
        step("bne_t", FETCH, 1, 0); step("bne_t", DECODE, 1, 0); step("bne_t", BRANCH, 1, 0);
        step("bne_n", FETCH, 1, 0); step("bne_n", DECODE, 1, 1); step("bne_n", BRANCH, 1, 1);

        op = 6'b100011;
        step("lw_stall", FETCH, 1, 0); step("lw_stall", DECODE, 1, 0);
        step("lw_stall", MEMADR, 1, 0);
        step("lw_stall", MEMRD, 0, 0); step("lw_stall", MEMRD, 0, 0);
        step("lw_stall", MEMRD, 0, 0); step("lw_stall", MEMRD, 1, 0);
        step("lw_stall", MEMWB, 1, 0);
        op = 6'b101011;
        step("sw_stall", FETCH, 1, 0); step("sw_stall", DECODE, 1, 0);
        step("sw_stall", MEMADR, 1, 0);
        step("sw_stall", MEMWR, 0, 0); step("sw_stall", MEMWR, 0, 0);
        step("sw_stall", MEMWR, 1, 0);
        step("fetch_stall1", FETCH, 0, 0); step("fetch_stall1", FETCH, 1, 0);
        step("after_stall", DECODE, 1, 0); step("after_stall", MEMADR, 1, 0);
        step("after_stall", MEMWR, 1, 0);

        op = 6'b100011;
        step("mid_reset", FETCH, 1, 0); step("mid_reset", DECODE, 1, 0);
        step("mid_reset", MEMADR, 1, 0); step("mid_reset", MEMRD, 0, 0);
        do_reset();

        for (int i = 0; i < 4; i++) step("watchdog_wait", FETCH, 0, 0);
        step("watchdog_err", ERROR, 0, 0);
        step("watchdog_sticky", ERROR, 1, 0);
        step("watchdog_sticky", ERROR, 1, 1);
        do_reset();

        op = 6'b111111;
        step("bad_op", FETCH, 1, 0); step("bad_op", DECODE, 1, 0);
        step("bad_op", ERROR, 1, 0); step("bad_op", ERROR, 1, 0);
        do_reset();
        op = 6'b000000; funct = 6'b000000;
        step("bad_funct", FETCH, 1, 0); step("bad_funct", DECODE, 1, 0);
        step("bad_funct", ERROR, 1, 0);
        do_reset();
        op = 6'b000010;
        step("post_reset", FETCH, 1, 0); step("post_reset", DECODE, 1, 0);
        step("post_reset", JUMP, 1, 0);

        repeat (300) @(posedge clk);
        #1;
        total++;
        if (act2 !== exp_vec(FETCH, op, funct, zero, 1'b0, 1'b1)) begin
            bad++;
            $display("FAIL no_watchdog: got state=%0d vec=%b expected state=0 err=0",
                     act2[19:16], act2[15:0]);
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
